// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 8-bit ALU between two requesters.
// Accepts one operation at a time over valid/ready, grants round-robin under
// contention, holds registered operands/select on the ALU for SETTLE_CYCLES
// edges, then captures RESULT/ZERO into a response register held until consumed.
// Ports:
//   clk_i, reset_i                 clock, synchronous active-high reset
//   req_valid{0,1}_i / req_ready{0,1}_o   request handshake per requester
//   req_data1_{0,1}_i, req_data2_{0,1}_i, req_select{0,1}_i  operation payload
//   alu_data1_o, alu_data2_o, alu_select_o  registered ALU inputs
//   alu_result_i, alu_zero_i       ALU outputs
//   rsp_valid_o / rsp_ready_i      response handshake
//   rsp_id_o, rsp_result_o, rsp_zero_o     response payload
//   busy_o                         registered, high whenever not idle
module alu_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       req_valid0_i,
  input  logic       req_valid1_i,
  output logic       req_ready0_o,
  output logic       req_ready1_o,
  input  logic [7:0] req_data1_0_i,
  input  logic [7:0] req_data2_0_i,
  input  logic [7:0] req_data1_1_i,
  input  logic [7:0] req_data2_1_i,
  input  logic [2:0] req_select0_i,
  input  logic [2:0] req_select1_i,
  output logic [7:0] alu_data1_o,
  output logic [7:0] alu_data2_o,
  output logic [2:0] alu_select_o,
  input  logic [7:0] alu_result_i,
  input  logic       alu_zero_i,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic       rsp_id_o,
  output logic [7:0] rsp_result_o,
  output logic       rsp_zero_o,
  output logic       busy_o
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_grant_q, last_grant_d;
  logic [DATA_W-1:0]  alu_data1_q, alu_data1_d;
  logic [DATA_W-1:0]  alu_data2_q, alu_data2_d;
  logic [SEL_W-1:0]   alu_select_q, alu_select_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]  rsp_result_q, rsp_result_d;
  logic               rsp_zero_q, rsp_zero_d;
  logic               busy_q, busy_d;

  logic               grant_c;
  logic               accept_c;

  // Round-robin grant: a lone requester wins; under contention the one not served last wins.
  always_comb begin
    grant_c = 1'b0;
    if (req_valid0_i && req_valid1_i) begin
      grant_c = ~last_grant_q;
    end else if (req_valid1_i) begin
      grant_c = 1'b1;
    end
  end

  assign accept_c     = (state_q == IDLE) && (req_valid0_i || req_valid1_i);
  assign req_ready0_o = (state_q == IDLE) && req_valid0_i && !grant_c;
  assign req_ready1_o = (state_q == IDLE) && req_valid1_i &&  grant_c;

  // Next-state and register updates.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    alu_data1_d  = alu_data1_q;
    alu_data2_d  = alu_data2_q;
    alu_select_d = alu_select_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;

    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          alu_data1_d  = grant_c ? req_data1_1_i : req_data1_0_i;
          alu_data2_d  = grant_c ? req_data2_1_i : req_data2_0_i;
          alu_select_d = grant_c ? req_select1_i : req_select0_i;
          last_grant_d = grant_c;
          rsp_id_d     = grant_c;
          cnt_d        = CNT_W'(SETTLE_CYCLES - 1);
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        // ALU inputs stay put; capture on the edge where the countdown is exhausted.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          rsp_result_d = alu_result_i;
          rsp_zero_d   = alu_zero_i;
          rsp_valid_d  = 1'b1;
          state_d      = DONE;
        end
      end
      DONE: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State register; reset discards any in-flight operation.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      alu_data1_q  <= '0;
      alu_data2_q  <= '0;
      alu_select_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      alu_data1_q  <= alu_data1_d;
      alu_data2_q  <= alu_data2_d;
      alu_select_q <= alu_select_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      busy_q       <= busy_d;
    end
  end

  assign alu_data1_o  = alu_data1_q;
  assign alu_data2_o  = alu_data2_q;
  assign alu_select_o = alu_select_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = rsp_id_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_zero_o   = rsp_zero_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed operations with hand-computed results,
// a response scoreboard/monitor, plus a SETTLE_CYCLES=1 instance.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  always #5 clk = ~clk;

  // Main DUT (SETTLE_CYCLES = 2)
  logic       v0 = 0, v1 = 0, r0, r1;
  logic [7:0] d10 = 0, d20 = 0, d11 = 0, d21 = 0;
  logic [2:0] s0 = 0, s1 = 0;
  logic [7:0] a1, a2, ares, rres;
  logic [2:0] asel;
  logic       azero, rvalid, rready = 1'b1, rid, rzero, busy;

  // SETTLE_CYCLES = 1 DUT
  logic       v0b = 0, r0b, r1b;
  logic [7:0] d10b = 0, d20b = 0;
  logic [2:0] s0b = 0;
  logic [7:0] a1b, a2b, aresb, rresb;
  logic [2:0] aselb;
  logic       azerob, rvalidb, ridb, rzerob, busyb;

  // Behavioural ALU shared by both instances.
  function automatic logic [7:0] alu_f(input logic [7:0] x, input logic [7:0] y, input logic [2:0] s);
    logic [15:0] dbl;
    case (s)
      3'd0: alu_f = x;
      3'd1: alu_f = x + y;
      3'd2: alu_f = x & y;
      3'd3: alu_f = x | y;
      3'd4: alu_f = 8'(x * y);
      3'd5: alu_f = x << y[2:0];
      3'd6: alu_f = 8'($signed(x) >>> y[2:0]);
      default: begin
        dbl   = {x, x} >> y[2:0];
        alu_f = dbl[7:0];
      end
    endcase
  endfunction

  assign ares   = alu_f(a1, a2, asel);
  assign azero  = (ares == 8'h00);
  assign aresb  = alu_f(a1b, a2b, aselb);
  assign azerob = (aresb == 8'h00);

  alu_arbiter #(.SETTLE_CYCLES(2)) dut (
    .clk_i(clk), .reset_i(reset),
    .req_valid0_i(v0), .req_valid1_i(v1), .req_ready0_o(r0), .req_ready1_o(r1),
    .req_data1_0_i(d10), .req_data2_0_i(d20), .req_data1_1_i(d11), .req_data2_1_i(d21),
    .req_select0_i(s0), .req_select1_i(s1),
    .alu_data1_o(a1), .alu_data2_o(a2), .alu_select_o(asel),
    .alu_result_i(ares), .alu_zero_i(azero),
    .rsp_valid_o(rvalid), .rsp_ready_i(rready), .rsp_id_o(rid),
    .rsp_result_o(rres), .rsp_zero_o(rzero), .busy_o(busy)
  );

  alu_arbiter #(.SETTLE_CYCLES(1)) dut1 (
    .clk_i(clk), .reset_i(reset),
    .req_valid0_i(v0b), .req_valid1_i(1'b0), .req_ready0_o(r0b), .req_ready1_o(r1b),
    .req_data1_0_i(d10b), .req_data2_0_i(d20b), .req_data1_1_i(8'h00), .req_data2_1_i(8'h00),
    .req_select0_i(s0b), .req_select1_i(3'd0),
    .alu_data1_o(a1b), .alu_data2_o(a2b), .alu_select_o(aselb),
    .alu_result_i(aresb), .alu_zero_i(azerob),
    .rsp_valid_o(rvalidb), .rsp_ready_i(1'b1), .rsp_id_o(ridb),
    .rsp_result_o(rresb), .rsp_zero_o(rzerob), .busy_o(busyb)
  );

  typedef struct packed {
    logic       id;
    logic [7:0] result;
    logic       zero;
  } rsp_t;

  rsp_t exp_q[$];
  int   acc_q[$];
  int   last_acc[2];
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic rsp_t mk(input logic id, input logic [7:0] res);
    rsp_t e;
    e.id = id; e.result = res; e.zero = (res == 8'h00);
    return e;
  endfunction

  // Monitor: latency on response rise, payload on consumption.
  logic rvalid_prev = 1'b0;
  always @(negedge clk) begin
    if (rvalid && !rvalid_prev) begin
      if (acc_q.size() == 0) chk("latency_no_accept", 32'd1, 32'd0);
      else chk("latency", 32'(cyc - acc_q.pop_front()), 32'd2);
    end
    if (rvalid && rready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", {24'h0, rres}, 32'hFFFF_FFFF);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_id", 32'(rid), 32'(e.id));
        chk("rsp_result", 32'(rres), 32'(e.result));
        chk("rsp_zero", 32'(rzero), 32'(e.zero));
      end
    end
    rvalid_prev <= rvalid;
  end

  // Drive one request, wait (bounded) for acceptance, check ALU inputs afterwards.
  task automatic send(input logic id, input logic [7:0] x, input logic [7:0] y, input logic [2:0] s);
    int n = 0;
    bit got = 0;
    int acc;
    @(posedge clk); #1;
    if (id) begin v1 = 1; d11 = x; d21 = y; s1 = s; end
    else    begin v0 = 1; d10 = x; d20 = y; s0 = s; end
    while (!got && n < 60) begin
      @(negedge clk);
      if ((id ? r1 : r0) === 1'b1) got = 1; else n++;
    end
    if (!got) begin
      chk("accept_timeout", 32'd0, 32'd1);
      if (id) v1 = 0; else v0 = 0;
      return;
    end
    acc = cyc + 1;
    @(posedge clk); #1;
    if (id) v1 = 0; else v0 = 0;
    acc_q.push_back(acc);
    last_acc[id] = acc;
    chk("alu_select", 32'(asel), 32'(s));
    chk("alu_data1", 32'(a1), 32'(x));
    chk("alu_data2", 32'(a2), 32'(y));
    chk("busy", 32'(busy), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 100) begin @(negedge clk); n++; end
    if (exp_q.size() > 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin : main
    int c, n;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_alu_data1", 32'(a1), 32'd0);
    chk("rst_alu_select", 32'(asel), 32'd0);
    chk("rst_rsp_valid", 32'(rvalid), 32'd0);
    chk("rst_rsp_result", 32'(rres), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready1", 32'(r1), 32'd0);

    // Contention from reset: req0 first, then req1; again req0 first.
    exp_q.push_back(mk(0, 8'h30));
    exp_q.push_back(mk(1, 8'hFF));
    fork
      send(0, 8'hF0, 8'h3C, 3'd2);
      send(1, 8'hF0, 8'h0F, 3'd3);
    join
    drain();
    exp_q.push_back(mk(0, 8'h0C));
    exp_q.push_back(mk(1, 8'h08));
    fork
      send(0, 8'h03, 8'h04, 3'd4);
      send(1, 8'h01, 8'h03, 3'd5);
    join
    drain();

    // Single ADD and zero flag.
    exp_q.push_back(mk(0, 8'h08));
    send(0, 8'h05, 8'h03, 3'd1);
    drain();
    exp_q.push_back(mk(1, 8'h00));
    send(1, 8'h05, 8'hFB, 3'd1);
    drain();

    // Backpressure: ROR held while req1 waits; req1 accepted one edge after consume.
    rready = 0;
    exp_q.push_back(mk(0, 8'hC0));
    exp_q.push_back(mk(1, 8'h11));
    send(0, 8'h81, 8'h01, 3'd7);
    last_acc[1] = -1;
    fork
      send(1, 8'h11, 8'h00, 3'd0);
    join_none
    n = 0;
    while (rvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    repeat (5) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(rvalid), 32'd1);
      chk("bp_rsp_result", 32'(rres), 32'hC0);
      chk("bp_ready0", 32'(r0), 32'd0);
      chk("bp_ready1", 32'(r1), 32'd0);
    end
    @(posedge clk); #1;
    rready = 1;
    c = cyc;
    wait fork;
    chk("bp_resume_edge", 32'(last_acc[1]), 32'(c + 2));
    drain();

    // Reset during ISSUE of MULT: no response, outputs back to reset values.
    send(0, 8'h03, 8'h04, 3'd4);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    acc_q.delete();
    @(negedge clk);
    chk("mid_rst_alu_data1", 32'(a1), 32'd0);
    chk("mid_rst_alu_data2", 32'(a2), 32'd0);
    chk("mid_rst_alu_select", 32'(asel), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rvalid), 32'd0);
    repeat (6) begin
      @(negedge clk);
      chk("mid_rst_no_rsp", 32'(rvalid), 32'd0);
    end
    exp_q.push_back(mk(0, 8'h2A));
    send(0, 8'h2A, 8'h00, 3'd0);
    drain();

    // SETTLE_CYCLES=1 instance: SRA 0x80 by 2.
    @(posedge clk); #1;
    v0b = 1; d10b = 8'h80; d20b = 8'h02; s0b = 3'd6;
    n = 0;
    while (r0b !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("s1_accepted", 32'(r0b), 32'd1);
    @(posedge clk); #1;
    v0b = 0;
    @(negedge clk);
    chk("s1_no_rsp_yet", 32'(rvalidb), 32'd0);
    @(negedge clk);
    chk("s1_rsp_valid", 32'(rvalidb), 32'd1);
    chk("s1_rsp_result", 32'(rresb), 32'hE0);
    chk("s1_rsp_zero", 32'(rzerob), 32'd0);
    chk("s1_rsp_id", 32'(ridb), 32'd0);

    chk("leftover_expected", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencing and arbitration controller that shares one 8-bit `alu` instance between two requesters, such as the instruction datapath and a debug/test port. It accepts one operation at a time over a valid/ready handshake and grants round-robin under contention. It holds registered operands and function select on the ALU inputs for a programmable number of settle cycles, then captures RESULT and ZERO into a response register. The block sits between the requesters and the ALU's DATA1/DATA2/SELECT/RESULT/ZERO pins.

## Interface
- SETTLE_CYCLES, 2: clock edges the ALU inputs are held before capture. Range 1..15. Must cover the worst ALU path, which is MULT.
- CLK  in  1  system clock; all state changes on posedge
- RESET  in  1  synchronous, active-high; clears all state
- REQ_VALID0, REQ_VALID1  in  1 each  requester has an operation pending
- REQ_READY0, REQ_READY1  out  1 each  operation accepted on this edge when valid & ready
- REQ_DATA1_0, REQ_DATA2_0, REQ_DATA1_1, REQ_DATA2_1  in  8 each  operands per requester
- REQ_SELECT0, REQ_SELECT1  in  3 each  ALU function code per requester (0 FORWARD, 1 ADD, 2 AND, 3 OR, 4 MULT, 5 SLL, 6 SRA, 7 ROR)
- ALU_DATA1, ALU_DATA2  out  8 each  registered operands to the ALU
- ALU_SELECT  out  3  registered function code to the ALU
- ALU_RESULT  in  8  ALU RESULT
- ALU_ZERO  in  1  ALU ZERO
- RSP_VALID  out  1  response held until consumed
- RSP_READY  in  1  consumer accepts response
- RSP_ID  out  1  requester index that owns the response
- RSP_RESULT  out  8  captured ALU result
- RSP_ZERO  out  1  captured ALU zero flag
- BUSY  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ISSUE, DONE. Reset state is IDLE.
- Reset values: ALU_DATA1/ALU_DATA2 = 0, ALU_SELECT = 0, RSP_* = 0, BUSY = 0, settle counter = 0, LAST_GRANT = 1 (so requester 0 wins the first contention).
- Grant, evaluated combinationally in IDLE:
  - If only one REQ_VALID is high, that requester is granted.
  - If both are high, the requester ≠ LAST_GRANT is granted.
  - REQ_READYn = IDLE & REQ_VALIDn & (grant == n). Both READYs are 0 outside IDLE.
- IDLE → ISSUE on an accept edge:
  - Load ALU_DATA1/2 and ALU_SELECT from the granted requester.
  - LAST_GRANT ← grant; RSP_ID ← grant; counter ← SETTLE_CYCLES−1.
- ISSUE:
  - ALU_* registers are held constant.
  - If counter ≠ 0, decrement.
  - If counter == 0, on that edge capture RSP_RESULT ← ALU_RESULT and RSP_ZERO ← ALU_ZERO, set RSP_VALID ← 1, and go to DONE.
- DONE:
  - RSP_* are held stable.
  - On an edge with RSP_READY = 1, RSP_VALID ← 0 and go to IDLE.
  - No new request is accepted in the same edge the response is consumed.
- Request inputs are ignored outside IDLE. A requester holds DATA/SELECT stable while VALID is high and not yet accepted.
- The block performs no arithmetic. Widths and signedness are the ALU's; RESULT and ZERO pass through unmodified. ALU_SELECT is never re-driven mid-operation.
- RESET has priority over every transition. Reset in ISSUE or DONE discards the in-flight operation, and no response is produced.

## Timing
- Accept-to-response latency: RSP_VALID rises exactly SETTLE_CYCLES edges after the accept edge.
- With RSP_READY tied high, throughput is one operation per SETTLE_CYCLES+2 cycles:
  - accept edge;
  - SETTLE_CYCLES edges in ISSUE, ending with the capture edge that sets RSP_VALID;
  - consume edge returning to IDLE;
  - next accept on the following edge.
- ALU inputs change only on the accept edge, so the ALU sees stable inputs for SETTLE_CYCLES full periods. The clock period × SETTLE_CYCLES must exceed the ALU's worst delay.
- REQ_READY is a combinational function of the state, REQ_VALID and LAST_GRANT only. It has no path from RSP_READY.
- BUSY is registered and equals (state ≠ IDLE).

## Test plan
- Single ADD: req0 sends 0x05, 0x03, SELECT=1 with SETTLE_CYCLES=2 → ALU_SELECT=1 after the accept edge. RSP_VALID rises 2 edges later with RSP_RESULT=0x08, RSP_ZERO=0, RSP_ID=0.
- Zero flag: req1 sends ADD 0x05 + 0xFB → RSP_RESULT=0x00, RSP_ZERO=1, RSP_ID=1.
- Contention fairness: both valid from reset, req0 AND 0xF0,0x3C and req1 OR 0xF0,0x0F, held valid → responses are req0 0x30 first, then req1 0xFF. Re-raise both again → req0 served next, because LAST_GRANT=1.
- Backpressure: ROR 0x81 by 0x01 with RSP_READY held low 5 cycles → RSP_RESULT=0xC0 stable and REQ_READY0/1 = 0 throughout. Accept resumes one edge after RSP_READY goes high.
- Reset mid-operation: assert RESET for 1 cycle during ISSUE of MULT 0x03×0x04 → all outputs return to reset values next edge and no RSP_VALID ever appears. A following FORWARD 0x2A returns 0x2A.
- SETTLE_CYCLES=1 build: SRA 0x80 by 0x02 → RSP_VALID on the first edge after accept, RSP_RESULT=0xE0.
